// File: rtl/bias_buffer_ctrl.sv
// Bias register file: captures a runtime-sized set of bias words during a load
// phase, then replays them in order with 1-based indices and last-channel marking.
module bias_buffer_ctrl #(
    parameter int WD      = 8,
    parameter int MAX_NUM = 128,
    parameter int NW      = 8
) (
    input  logic          i_sclk,
    input  logic          i_rst,
    input  logic [NW-1:0] i_cfg_num,
    input  logic          i_load_start,
    input  logic          i_ld_en,
    input  logic [WD-1:0] i_ld_data,
    output logic          o_ld_done,
    output logic          o_ready,
    input  logic          i_rd_en,
    output logic          o_b_en,
    output logic [NW-1:0] o_b_num,
    output logic          o_b_last,
    output logic [WD-1:0] o_bias,
    input  logic          i_err_clr,
    output logic          o_err
);

    localparam int            AW        = (MAX_NUM > 1) ? $clog2(MAX_NUM) : 1;
    localparam logic [NW-1:0] MAX_NUM_W = NW'(MAX_NUM);
    localparam logic [NW-1:0] ONE_W     = NW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [NW-1:0] num_q, num_d;
    logic [NW-1:0] wr_ptr_q, wr_ptr_d;
    logic [NW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ld_done_q, ld_done_d;
    logic          ready_q, ready_d;
    logic          b_en_q, b_en_d;
    logic          b_last_q, b_last_d;
    logic          err_q, err_d;
    logic [NW-1:0] b_num_q, b_num_d;
    logic [WD-1:0] bias_q, bias_d;

    logic [WD-1:0] mem [MAX_NUM];

    logic cfg_ok_s;
    logic start_s;
    logic bad_start_s;
    logic wr_last_s;
    logic rd_last_s;
    logic mem_we_s;
    logic err_set_s;

    assign cfg_ok_s    = (i_cfg_num != '0) && (i_cfg_num <= MAX_NUM_W);
    assign start_s     = i_load_start && cfg_ok_s;
    assign bad_start_s = i_load_start && !cfg_ok_s;
    assign wr_last_s   = (wr_ptr_q == (num_q - ONE_W));
    assign rd_last_s   = (rd_ptr_q == (num_q - ONE_W));

    // Next-state, pointer, output and error-flag logic.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ld_done_d = 1'b0;
        b_en_d    = 1'b0;
        b_last_d  = 1'b0;
        b_num_d   = b_num_q;
        bias_d    = bias_q;
        mem_we_s  = 1'b0;
        err_set_s = bad_start_s;

        // A valid start overrides any load, read or write in the same cycle.
        if (start_s) begin
            num_d    = i_cfg_num;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (i_rd_en) begin
                        err_set_s = 1'b1;
                    end else begin
                        err_set_s = bad_start_s;
                    end
                    if (i_ld_en) begin
                        mem_we_s = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_W;
                        if (wr_last_s) begin
                            state_d   = ST_READY;
                            ld_done_d = 1'b1;
                        end else begin
                            state_d   = ST_LOAD;
                        end
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
                ST_READY: begin
                    if (i_rd_en) begin
                        b_en_d   = 1'b1;
                        bias_d   = mem[rd_ptr_q[AW-1:0]];
                        b_num_d  = rd_ptr_q + ONE_W;
                        b_last_d = rd_last_s;
                        rd_ptr_d = rd_last_s ? '0 : (rd_ptr_q + ONE_W);
                    end else begin
                        b_en_d   = 1'b0;
                    end
                end
                default: begin
                    if (i_rd_en) begin
                        err_set_s = 1'b1;
                    end else begin
                        err_set_s = bad_start_s;
                    end
                end
            endcase
        end

        ready_d = (state_d == ST_READY);

        // Set takes priority over clear.
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (i_err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ld_done_q <= 1'b0;
            ready_q   <= 1'b0;
            b_en_q    <= 1'b0;
            b_last_q  <= 1'b0;
            err_q     <= 1'b0;
            b_num_q   <= '0;
            bias_q    <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ld_done_q <= ld_done_d;
            ready_q   <= ready_d;
            b_en_q    <= b_en_d;
            b_last_q  <= b_last_d;
            err_q     <= err_d;
            b_num_q   <= b_num_d;
            bias_q    <= bias_d;
        end
    end

    // Bias storage; contents survive reset.
    always_ff @(posedge i_sclk) begin
        if (mem_we_s && !i_rst) begin
            mem[wr_ptr_q[AW-1:0]] <= i_ld_data;
        end
    end

    assign o_ld_done = ld_done_q;
    assign o_ready   = ready_q;
    assign o_b_en    = b_en_q;
    assign o_b_num   = b_num_q;
    assign o_b_last  = b_last_q;
    assign o_bias    = bias_q;
    assign o_err     = err_q;

endmodule

// File: doc/bias_buffer_ctrl.md
Name: bias_buffer_ctrl

Overview:
Parametrised successor to the fully-connected bias pass-through. Captures a runtime-configurable number of bias words into a local register file during a load phase. Replays them on demand, in order, with 1-based channel indices, wrap-around and last-channel marking. Sits between the bias loader and any conv/FC accumulator stage needing per-output-channel bias; one bias is replayed per read request.

Parameters:
WD, 8, bias word width in bits
MAX_NUM, 128, register-file depth; maximum biases per layer
NW, 8, width of count/index fields; must hold MAX_NUM

Ports:
i_sclk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_cfg_num  in  NW  bias count for next layer, sampled on i_load_start
i_load_start  in  1  pulse: begin new load sequence
i_ld_en  in  1  load data valid
i_ld_data  in  WD  bias word to store
o_ld_done  out  1  one-cycle pulse: load sequence complete
o_ready  out  1  high while in READY state
i_rd_en  in  1  request next bias
o_b_en  out  1  output bias valid
o_b_num  out  NW  1-based index of o_bias (1..num)
o_b_last  out  1  high with o_b_en when index == num
o_bias  out  WD  bias value
i_err_clr  in  1  clears o_err
o_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (i_rst=1 at clock edge): state=IDLE; wr_ptr, rd_ptr, num_q = 0; o_ld_done, o_ready, o_b_en, o_b_last, o_err = 0; o_b_num, o_bias = 0. Register-file contents are not reset. Reset mid-load or mid-replay aborts immediately; a new load is required.
- States: IDLE, LOAD, READY.
- i_load_start in any state:
  - i_cfg_num in 1..MAX_NUM: latch num_q, wr_ptr=0, rd_ptr=0, go to LOAD next cycle.
  - i_cfg_num == 0 or > MAX_NUM: start ignored, state unchanged, o_err set.
  - In LOAD: restarts the sequence; prior partial data is discarded.
- LOAD:
  - Each i_ld_en cycle writes i_ld_data to mem[wr_ptr] and increments wr_ptr.
  - Write with wr_ptr == num_q-1: go to READY; o_ld_done pulses one cycle in the cycle after that write.
  - i_rd_en in LOAD: ignored, o_err set.
  - i_ld_en together with i_load_start: the start wins and the data is dropped.
- READY:
  - o_ready=1.
  - i_rd_en at edge N: at edge N+1, o_b_en=1, o_bias=mem[rd_ptr], o_b_num=rd_ptr+1, o_b_last=(rd_ptr==num_q-1). Latency is one cycle; back-to-back requests give one output per cycle.
  - rd_ptr increments per request and wraps from num_q-1 to 0, so replay repeats indefinitely for multiple spatial positions.
  - i_ld_en in READY: ignored, no error.
  - i_load_start with i_rd_en in the same cycle: load wins, read dropped, no o_b_en, no error.
- IDLE:
  - i_rd_en sets o_err and produces no output.
  - i_ld_en is ignored.
- o_b_en, o_b_last and o_ld_done are 0 in every cycle without a qualifying event. o_bias and o_b_num hold their last values when o_b_en=0.
- o_err is set by any of the error events above and cleared only by i_err_clr or i_rst. If set and clear coincide, set wins.
- Width rules: o_b_num = rd_ptr+1 computed in NW bits. With MAX_NUM < 2^NW there is no overflow. No arithmetic on bias data; values pass unmodified.

Test Plan:
- Reset, then load num=4 with data 0x11,0x22,0x33,0x44 (i_ld_en continuous) -> o_ld_done pulses one cycle after 4th write; o_ready=1.
- After that load, 10 back-to-back i_rd_en -> o_b_num sequence 1,2,3,4,1,2,3,4,1,2 one cycle after each request; o_bias matches; o_b_last=1 on every num 4.
- Load num=MAX_NUM=128 with data=index, i_ld_en gapped every other cycle, then read 128 -> all values correct; o_b_last only at 128.
- i_load_start with i_cfg_num=0, then 129 -> state stays, o_err=1; i_err_clr -> o_err=0 next cycle; i_rd_en in IDLE -> o_err=1, o_b_en stays 0.
- In READY, mid-replay (after index 2), assert i_load_start with i_rd_en, num=3 -> no o_b_en; after reload of 0xA,0xB,0xC, reads give 1,2,3 from index 1.
- Assert i_rst during LOAD after 2 of 4 writes -> all outputs 0 next cycle; state IDLE; subsequent i_rd_en flags o_err.
